// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder
//   Receive side of a gray-coded CDC progress path. It resynchronises an
//   asynchronous gray count into the clk domain and decodes it to binary.
//   Each observed change is checked as a legal +1 advance modulo 2^N_BITS.
//
// Ports
//   clk        destination-domain clock
//   nrst       synchronous active-low reset (dominates every other input)
//   gray_in    gray-coded count, asynchronous to clk
//   err_clr    level clear for the sticky error flag
//   gray_sync  last stage of the synchroniser chain
//   bin_out    registered binary decode of gray_sync
//   step       one-cycle pulse when the decoded value advanced by exactly +1
//   err        sticky flag: an illegal change was observed
//   step_cnt   saturating count of legal advances since reset
module gray_sync_decoder #(
    parameter int N_BITS      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [N_BITS-1:0] gray_in,
    input  logic              err_clr,
    output logic [N_BITS-1:0] gray_sync,
    output logic [N_BITS-1:0] bin_out,
    output logic              step,
    output logic              err,
    output logic [CNT_W-1:0]  step_cnt
);

    logic [N_BITS-1:0] sync_q [SYNC_STAGES];
    logic [N_BITS-1:0] sync_d [SYNC_STAGES];
    logic [N_BITS-1:0] bin_q, bin_d;
    logic              step_q, step_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_BITS-1:0] dec;
    logic [N_BITS-1:0] delta;

    // Plain flop chain: no logic between stages so only one bit of the gray
    // word can be in flight per sample.
    always_comb begin
        sync_d[0] = gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Binary bit i is the XOR of all gray bits from i upwards.
    always_comb begin
        dec = '0;
        for (int i = 0; i < N_BITS; i++) begin
            dec[i] = ^(sync_q[SYNC_STAGES-1] >> i);
        end
    end

    // Wrap arithmetic makes 2^N-1 -> 0 a delta of one.
    assign delta = dec - bin_q;

    always_comb begin
        bin_d  = dec;
        step_d = 1'b0;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (delta == N_BITS'(1)) begin
            step_d = 1'b1;
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (delta != '0) begin
            // Setting the flag overrides a simultaneous clear.
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            bin_q  <= '0;
            step_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            bin_q  <= bin_d;
            step_q <= step_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign gray_sync = sync_q[SYNC_STAGES-1];
    assign bin_out   = bin_q;
    assign step      = step_q;
    assign err       = err_q;
    assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
module tb_gray_sync_decoder;

    typedef struct {
        logic [3:0] bin;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       nrst, err_clr;
    logic [3:0] gray_in;
    logic [3:0] gray_sync, bin_out;
    logic       step, err;
    logic [7:0] step_cnt;

    logic       nrst2, err_clr2;
    logic [3:0] gray_in2;
    logic [3:0] gray_sync2, bin_out2;
    logic       step2, err2;
    logic [1:0] step_cnt2;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic prev_step1 = 1'b0;
    logic prev_step2 = 1'b0;

    always #5 clk = ~clk;

    gray_sync_decoder #(.N_BITS(4), .SYNC_STAGES(2), .CNT_W(8)) u_dut (
        .clk(clk), .nrst(nrst), .gray_in(gray_in), .err_clr(err_clr),
        .gray_sync(gray_sync), .bin_out(bin_out), .step(step), .err(err),
        .step_cnt(step_cnt)
    );

    gray_sync_decoder #(.N_BITS(4), .SYNC_STAGES(2), .CNT_W(2)) u_dut2 (
        .clk(clk), .nrst(nrst2), .gray_in(gray_in2), .err_clr(err_clr2),
        .gray_sync(gray_sync2), .bin_out(bin_out2), .step(step2), .err(err2),
        .step_cnt(step_cnt2)
    );

    function automatic logic [3:0] b2g(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every step pulse consumes one expected entry.
    always @(negedge clk) begin
        if (nrst && step) begin
            exp_t e;
            n_tests++;
            if (prev_step1) begin
                n_fail++;
                $display("FAIL dut1_double_step: step high two cycles running");
            end else if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL dut1_unexpected_step: bin_out=%0d step_cnt=%0d, none expected", bin_out, step_cnt);
            end else begin
                e = q1.pop_front();
                if (bin_out !== e.bin || step_cnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL dut1_step: bin_out=%0d step_cnt=%0d expected bin_out=%0d step_cnt=%0d",
                             bin_out, step_cnt, e.bin, e.cnt);
                end
            end
        end
        prev_step1 <= step;
    end

    always @(negedge clk) begin
        if (nrst2 && step2) begin
            exp_t e;
            n_tests++;
            if (prev_step2) begin
                n_fail++;
                $display("FAIL dut2_double_step: step high two cycles running");
            end else if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL dut2_unexpected_step: bin_out=%0d step_cnt=%0d, none expected", bin_out2, step_cnt2);
            end else begin
                e = q2.pop_front();
                if (bin_out2 !== e.bin || 8'(step_cnt2) !== e.cnt) begin
                    n_fail++;
                    $display("FAIL dut2_step: bin_out=%0d step_cnt=%0d expected bin_out=%0d step_cnt=%0d",
                             bin_out2, step_cnt2, e.bin, e.cnt);
                end
            end
        end
        prev_step2 <= step2;
    end

    initial begin
        logic [3:0] bin6 [5];
        logic [7:0] cnt6 [5];
        bin6 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        cnt6 = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

        nrst     = 1'b0;
        err_clr  = 1'b0;
        gray_in  = 4'b1011;
        nrst2    = 1'b0;
        err_clr2 = 1'b0;
        gray_in2 = 4'b0000;

        // 1: reset state
        tick(2);
        chk("rst_gray_sync", gray_sync, 0);
        chk("rst_bin_out", bin_out, 0);
        chk("rst_step", step, 0);
        chk("rst_err", err, 0);
        chk("rst_step_cnt", step_cnt, 0);

        nrst    = 1'b1;
        gray_in = 4'b0000;
        tick(4);
        chk("idle_bin_out", bin_out, 0);
        chk("idle_err", err, 0);

        // 2: single advance, latency of three edges
        gray_in = 4'b0001;
        q1.push_back('{bin: 4'd1, cnt: 8'd1});
        tick(2);
        chk("lat_step_early", step, 0);
        chk("lat_bin_early", bin_out, 0);
        tick(1);
        chk("lat_step", step, 1);
        chk("lat_bin", bin_out, 1);
        tick(1);
        chk("lat_step_low", step, 0);
        tick(4);
        chk("adv1_cnt", step_cnt, 1);

        // 3: full gray walk with wrap, from a fresh reset
        nrst    = 1'b0;
        gray_in = 4'b0000;
        tick(2);
        nrst = 1'b1;
        tick(3);
        for (int i = 1; i <= 16; i++) begin
            gray_in = b2g(i % 16);
            q1.push_back('{bin: 4'(i % 16), cnt: 8'(i)});
            tick(4);
        end
        tick(2);
        chk("walk_bin_out", bin_out, 0);
        chk("walk_err", err, 0);
        chk("walk_step_cnt", step_cnt, 16);
        chk("walk_q_empty", q1.size(), 0);

        // 4: illegal jump 0 -> 2
        gray_in = 4'b0011;
        tick(3);
        chk("jump_bin_out", bin_out, 2);
        chk("jump_err", err, 1);
        chk("jump_step", step, 0);
        chk("jump_step_cnt", step_cnt, 16);
        tick(3);
        chk("jump_err_sticky", err, 1);

        // 5: clear, then illegal jump with clear held (set wins)
        err_clr = 1'b1;
        tick(1);
        chk("clr_err", err, 0);
        err_clr = 1'b0;
        tick(2);
        gray_in = 4'b0100;
        err_clr = 1'b1;
        tick(3);
        chk("setwins_bin_out", bin_out, 7);
        chk("setwins_err", err, 1);
        err_clr = 1'b0;
        tick(2);
        chk("setwins_err_hold", err, 1);
        chk("setwins_step_cnt", step_cnt, 16);

        // mid-run reset of the wide instance
        gray_in = b2g(8);
        tick(1);
        nrst = 1'b0;
        tick(1);
        chk("midrst_gray_sync", gray_sync, 0);
        chk("midrst_bin_out", bin_out, 0);
        chk("midrst_err", err, 0);
        chk("midrst_step_cnt", step_cnt, 0);
        nrst = 1'b1;

        // 6: two-bit counter saturation
        nrst2 = 1'b1;
        tick(3);
        for (int i = 0; i < 5; i++) begin
            gray_in2 = b2g(i + 1);
            q2.push_back('{bin: bin6[i], cnt: cnt6[i]});
            tick(4);
        end
        chk("sat_step_cnt", step_cnt2, 3);
        chk("sat_err", err2, 0);
        chk("sat_q_empty", q2.size(), 0);
        gray_in2 = b2g(6);
        tick(1);
        nrst2 = 1'b0;
        tick(1);
        chk("sat_rst_gray_sync", gray_sync2, 0);
        chk("sat_rst_bin_out", bin_out2, 0);
        chk("sat_rst_step", step2, 0);
        chk("sat_rst_err", err2, 0);
        chk("sat_rst_step_cnt", step_cnt2, 0);

        tick(4);
        chk("final_q1_empty", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
